hash160_digest_tx: RTL and testbench

// - Transmit side of the Hash160 byte interface: streams a finished 160-bit digest out one byte per beat.
// - Sits behind the hash core, driven by its done flag and 160-bit answer.
// - Mirrors the core's 8-bit serial input path, in the outgoing direction.
// - Byte stream is valid/ready handshaked, as raw bytes or lowercase ASCII hex.

---
 rtl/hash160_pkg.sv | 15 +
 rtl/hash160_digest_tx_nibble_to_ascii.sv | 18 +
 rtl/hash160_digest_tx.sv | 101 ++++++++++
 tb/tb_hash160_digest_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hash160_pkg.sv
// Shared types and constants for the Hash160 byte interface.
// Combinational definitions only; no latency or backpressure of its own.
package hash160_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DIGEST_BYTES_DEF = 20;
  localparam logic [7:0]  ASCII_0          = 8'h30;
  localparam logic [7:0]  ASCII_A_LC       = 8'h61;

endpackage

// File: rtl/hash160_digest_tx_nibble_to_ascii.sv
// Maps one 4-bit nibble to its lowercase ASCII hex character.
// Purely combinational, zero latency, no handshake.
module nibble_to_ascii
  import hash160_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble <= 4'd9) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else begin
      ascii = ASCII_A_LC + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hash160_digest_tx.sv
// Streams a latched digest as raw bytes or ASCII hex over valid/ready; first beat one cycle after the i_valid rising edge.
// Holds o_byte stable while i_byte_ready is low; restart edges during SEND/DONE are dropped.
module hash160_digest_tx
  import hash160_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF,
  parameter int HEX_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [8*DIGEST_BYTES-1:0] i_digest,
  output logic [7:0]                o_byte,
  output logic                      o_byte_valid,
  input  logic                      i_byte_ready,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int             W     = 8 * DIGEST_BYTES;
  localparam int             BEATS = (HEX_MODE != 0) ? 2 * DIGEST_BYTES : DIGEST_BYTES;
  localparam int             CW    = $clog2(2 * DIGEST_BYTES + 1);
  localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);

  state_t          state, state_nxt;
  logic            i_valid_d;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [W-1:0]    sreg, sreg_nxt;
  logic            start;
  logic            beat;
  logic            shift_en;
  logic [7:0]      byte_sel;

  assign start = i_valid & ~i_valid_d;
  assign beat  = (state == SEND) & i_byte_ready;

  generate
    if (HEX_MODE != 0) begin : g_hex
      logic [3:0] nib;
      // Even beats carry the high nibble; the byte retires after the odd beat.
      assign nib      = cnt[0] ? sreg[W-5:W-8] : sreg[W-1:W-4];
      assign shift_en = cnt[0];
      nibble_to_ascii u_n2a (
        .nibble (nib),
        .ascii  (byte_sel)
      );
    end else begin : g_raw
      assign byte_sel = sreg[W-1:W-8];
      assign shift_en = 1'b1;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt  = i_digest;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          cnt_nxt = cnt + CW'(1);
          if (shift_en) begin
            sreg_nxt = {sreg[W-9:0], 8'h00};
          end
          if (cnt == LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i_valid_d <= 1'b0;
      cnt       <= '0;
      sreg      <= '0;
    end else begin
      state     <= state_nxt;
      i_valid_d <= i_valid;
      cnt       <= cnt_nxt;
      sreg      <= sreg_nxt;
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign o_byte_valid = (state == SEND);
  assign o_busy       = (state == SEND);
  assign o_done       = (state == DONE);
  assign o_byte       = o_byte_valid ? byte_sel : 8'h00;

endmodule

// File: tb/tb_hash160_digest_tx.sv
// Scoreboard bench for hash160_digest_tx: one raw-mode and one hex-mode instance.
module tb_hash160_digest_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, r0, r1;
  logic [159:0] d0, d1;
  logic [7:0]   b0, b1;
  logic         bv0, bv1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  hash160_digest_tx #(.DIGEST_BYTES(20), .HEX_MODE(0)) u_raw (
    .clk(clk), .rst(rst), .i_valid(v0), .i_digest(d0), .o_byte(b0),
    .o_byte_valid(bv0), .i_byte_ready(r0), .o_busy(busy0), .o_done(done0)
  );

  hash160_digest_tx #(.DIGEST_BYTES(20), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .i_valid(v1), .i_digest(d1), .o_byte(b1),
    .o_byte_valid(bv1), .i_byte_ready(r1), .o_busy(busy1), .o_done(done1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] hex_seen[$];
  int         beat_cyc0[$];
  int         beats0 = 0, beats1 = 0, dones0 = 0, dones1 = 0, done_cyc0 = 0;

  logic       bp = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         ph = 0;
  logic       p_vld = 1'b0, p_rdy = 1'b0;
  logic [7:0] p_byte = 8'h00;

  localparam logic [159:0] D_T2 = 160'h0123456789abcdef0011223344556677_8899aabb;
  localparam logic [159:0] D_HX = 160'hb472a266d0bd89c13706a4132ccfb16f7c3b9fcb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [159:0] rnd_digest();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_raw(input logic [159:0] d);
    for (int i = 0; i < 20; i++) q0.push_back(d[159-8*i -: 8]);
  endtask

  task automatic push_hex(input logic [159:0] d);
    logic [7:0] b;
    for (int i = 0; i < 20; i++) begin
      b = d[159-8*i -: 8];
      q1.push_back(hexc(b[7:4]));
      q1.push_back(hexc(b[3:0]));
    end
  endtask

  task automatic sample();
    if (rst) begin
      p_vld = 1'b0;
    end else begin
      if (p_vld && !p_rdy) begin
        check("raw_hold_vld", 32'(bv0), 32'd1);
        check("raw_hold_byte", 32'(b0), 32'(p_byte));
      end
      if (bv0 && r0) begin
        beats0++;
        beat_cyc0.push_back(cyc);
        check("raw_expected_beat", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) check("raw_byte", 32'(b0), 32'(q0.pop_front()));
      end
      if (done0) begin
        dones0++;
        done_cyc0 = cyc;
        check("raw_done_no_vld", 32'(bv0), 32'd0);
      end
      p_vld = bv0; p_rdy = r0; p_byte = b0;
      if (bv1 && r1) begin
        beats1++;
        hex_seen.push_back(b1);
        check("hex_expected_beat", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) check("hex_char", 32'(b1), 32'(q1.pop_front()));
      end
      if (done1) dones1++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (bp) begin
      r0 = bp_pat[ph];
      ph = (ph + 1) % 4;
    end
    @(negedge clk);
    sample();
  endtask

  task automatic wait_done0(input int budget, input string tag);
    int d = dones0;
    int n = 0;
    while (dones0 == d && n < budget) begin step(); n++; end
    check(tag, 32'(dones0 != d), 32'd1);
  endtask

  task automatic wait_done1(input int budget, input string tag);
    int d = dones1;
    int n = 0;
    while (dones1 == d && n < budget) begin step(); n++; end
    check(tag, 32'(dones1 != d), 32'd1);
  endtask

  initial begin
    int c, bb, bc, dd, hs, n;
    logic [159:0] dr;
    rst = 1'b1; v0 = 0; v1 = 0; r0 = 1; r1 = 1; d0 = '0; d1 = '0;
    #12;
    check("rst_byte", 32'(b0), 32'd0);
    check("rst_vld", 32'(bv0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_hex_byte", 32'(b1), 32'd0);
    check("rst_hex_vld", 32'(bv1), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // T1: async reset in the middle of a transfer
    dr = rnd_digest(); d0 = dr; v0 = 1; bb = beats0; push_raw(dr);
    n = 0;
    while (beats0 - bb < 7 && n < 50) begin step(); n++; end
    check("t1_reach_beat7", 32'(beats0 - bb), 32'd7);
    check("t1_pre_vld", 32'(bv0), 32'd1);
    rst = 1'b1; v0 = 0;
    #1;
    check("t1_async_vld", 32'(bv0), 32'd0);
    check("t1_async_busy", 32'(busy0), 32'd0);
    check("t1_async_byte", 32'(b0), 32'd0);
    check("t1_async_done", 32'(done0), 32'd0);
    q0.delete();
    repeat (2) step();
    rst = 1'b0;
    bb = beats0; dd = dones0;
    repeat (20) step();
    check("t1_no_beats", 32'(beats0 - bb), 32'd0);
    check("t1_no_done", 32'(dones0 - dd), 32'd0);
    check("t1_idle", 32'(busy0), 32'd0);

    // T2: raw stream, ready held high
    c = cyc; bb = beats0; bc = beat_cyc0.size();
    d0 = D_T2; v0 = 1; push_raw(D_T2);
    wait_done0(40, "t2_done_timeout");
    check("t2_beats", 32'(beats0 - bb), 32'd20);
    if (beat_cyc0.size() >= bc + 20) begin
      check("t2_first_lat", 32'(beat_cyc0[bc] - c), 32'd1);
      check("t2_last_lat", 32'(beat_cyc0[bc+19] - c), 32'd20);
    end
    check("t2_done_lat", 32'(done_cyc0 - c), 32'd21);
    check("t2_q_empty", 32'(q0.size()), 32'd0);
    v0 = 0;
    repeat (3) step();

    // T3: backpressure 1,0,0,1
    bp = 1; ph = 0; bb = beats0; dd = dones0;
    v0 = 1; push_raw(D_T2);
    wait_done0(200, "t3_done_timeout");
    repeat (10) step();
    bp = 0; r0 = 1;
    check("t3_beats", 32'(beats0 - bb), 32'd20);
    check("t3_done_once", 32'(dones0 - dd), 32'd1);
    check("t3_q_empty", 32'(q0.size()), 32'd0);
    v0 = 0;
    repeat (3) step();

    // T4: hex stream
    hs = hex_seen.size(); bb = beats1;
    d1 = D_HX; v1 = 1; push_hex(D_HX);
    wait_done1(80, "t4_done_timeout");
    check("t4_chars", 32'(beats1 - bb), 32'd40);
    if (hex_seen.size() >= hs + 2) begin
      check("t4_char0", 32'(hex_seen[hs]), 32'h62);
      check("t4_char1", 32'(hex_seen[hs+1]), 32'h34);
    end
    check("t4_q_empty", 32'(q1.size()), 32'd0);
    v1 = 0;
    repeat (3) step();

    // T5: level hold, ignored restart, re-arm after DONE
    bb = beats0; dd = dones0;
    dr = rnd_digest(); d0 = dr; v0 = 1; push_raw(dr);
    repeat (100) step();
    check("t5_hold_beats", 32'(beats0 - bb), 32'd20);
    check("t5_hold_done", 32'(dones0 - dd), 32'd1);
    v0 = 0;
    repeat (2) step();
    bb = beats0; dd = dones0;
    dr = rnd_digest(); d0 = dr; v0 = 1; push_raw(dr);
    repeat (5) step();
    v0 = 0;
    step();
    v0 = 1;
    wait_done0(60, "t5_pulse_timeout");
    repeat (30) step();
    check("t5_pulse_beats", 32'(beats0 - bb), 32'd20);
    check("t5_pulse_done", 32'(dones0 - dd), 32'd1);
    check("t5_pulse_idle", 32'(busy0), 32'd0);
    v0 = 0;
    repeat (2) step();
    bb = beats0;
    dr = rnd_digest(); d0 = dr; v0 = 1; push_raw(dr);
    wait_done0(60, "t5_rearm_timeout");
    check("t5_rearm_beats", 32'(beats0 - bb), 32'd20);
    v0 = 0;
    repeat (3) step();

    // T6: digest changes after beat 3
    bb = beats0;
    dr = rnd_digest(); d0 = dr; v0 = 1; push_raw(dr);
    repeat (4) step();
    check("t6_beats_before", 32'(beats0 - bb), 32'd4);
    d0 = ~dr;
    wait_done0(60, "t6_done_timeout");
    check("t6_beats", 32'(beats0 - bb), 32'd20);
    check("t6_q_empty", 32'(q0.size()), 32'd0);
    v0 = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
